// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between in-order writeback (priority) and a buffered
// long-latency result FIFO, with a starvation guard and pending-destination lookups for decode.
module regfile_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    output logic                     wb_stall,
    input  logic                     ll_valid,
    input  logic [4:0]               ll_reg,
    input  logic [31:0]              ll_data,
    output logic                     ll_ready,
    input  logic [4:0]               chk_reg_1,
    input  logic [4:0]               chk_reg_2,
    output logic                     chk_hit_1,
    output logic                     chk_hit_2,
    output logic [4:0]               write_reg,
    output logic [31:0]              write_data,
    output logic                     regWrite,
    output logic [$clog2(DEPTH):0]   ll_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t              r_state;
    logic [4:0]          r_q_reg  [DEPTH];
    logic [31:0]         r_q_data [DEPTH];
    logic [DEPTH-1:0]    r_q_vld;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [PW:0]         r_count;
    logic [CW-1:0]       r_wait;
    logic                r_regwrite;
    logic [4:0]          r_write_reg;
    logic [31:0]         r_write_data;

    logic                w_empty;
    logic                w_wb_acc;
    logic                w_push;
    logic                w_pop;
    logic                w_hit_1;
    logic                w_hit_2;

    assign w_empty  = (r_count == '0);
    assign ll_ready = (r_count != FULL_CNT);
    assign wb_stall = (r_state == DRAIN);
    assign w_wb_acc = wb_valid && !wb_stall;
    // Reg-0 LL results complete the handshake but never occupy a slot.
    assign w_push   = ll_valid && ll_ready && (ll_reg != 5'd0);
    assign w_pop    = !w_empty && ((r_state == DRAIN) || !w_wb_acc);

    assign regWrite   = r_regwrite;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;
    assign ll_count   = r_count;

    always_comb begin
        w_hit_1 = 1'b0;
        w_hit_2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_q_vld[i] && (r_q_reg[i] == chk_reg_1)) w_hit_1 = 1'b1;
            if (r_q_vld[i] && (r_q_reg[i] == chk_reg_2)) w_hit_2 = 1'b1;
        end
        if (r_regwrite && (r_write_reg == chk_reg_1)) w_hit_1 = 1'b1;
        if (r_regwrite && (r_write_reg == chk_reg_2)) w_hit_2 = 1'b1;
    end

    assign chk_hit_1 = (chk_reg_1 != 5'd0) && w_hit_1;
    assign chk_hit_2 = (chk_reg_2 != 5'd0) && w_hit_2;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_reg[r_wr_ptr]  <= ll_reg;
            r_q_data[r_wr_ptr] <= ll_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= NORMAL;
            r_q_vld      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_wait       <= '0;
            r_regwrite   <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 32'd0;
        end else begin
            if (w_push) begin
                r_q_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_q_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_wb_acc) begin
                r_regwrite   <= (wb_reg != 5'd0);
                r_write_reg  <= wb_reg;
                r_write_data <= wb_data;
            end else if (w_pop) begin
                r_regwrite   <= 1'b1;
                r_write_reg  <= r_q_reg[r_rd_ptr];
                r_write_data <= r_q_data[r_rd_ptr];
            end else begin
                r_regwrite   <= 1'b0;
            end

            // The cycle the head has waited MAX_WAIT cycles, the next cycle is a forced drain slot.
            case (r_state)
                NORMAL: begin
                    if (w_empty || w_pop) begin
                        r_wait <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                        if (r_wait == WAIT_LAST) r_state <= DRAIN;
                    end
                end
                default: begin
                    r_wait  <= '0;
                    r_state <= NORMAL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, WB writes, LL buffering, full FIFO,
// starvation drain, register-0 handling and asynchronous reset.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        ll_valid;
    logic [4:0]  ll_reg;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic [4:0]  chk_reg_1;
    logic [4:0]  chk_reg_2;
    logic        chk_hit_1;
    logic        chk_hit_2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        regWrite;
    logic [2:0]  ll_count;

    int n_vec = 0;
    int n_err = 0;

    regfile_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .wb_stall   (wb_stall),
        .ll_valid   (ll_valid),
        .ll_reg     (ll_reg),
        .ll_data    (ll_data),
        .ll_ready   (ll_ready),
        .chk_reg_1  (chk_reg_1),
        .chk_reg_2  (chk_reg_2),
        .chk_hit_1  (chk_hit_1),
        .chk_hit_2  (chk_hit_2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regWrite   (regWrite),
        .ll_count   (ll_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        ll_valid = 1'b0; ll_reg = 5'd0; ll_data = 32'd0;
        chk_reg_1 = 5'd0; chk_reg_2 = 5'd0;

        repeat (2) @(negedge clk);
        chk("rst_regwrite", 32'(regWrite), 32'd0);
        chk("rst_stall", 32'(wb_stall), 32'd0);
        chk("rst_count", 32'(ll_count), 32'd0);
        chk("rst_wreg", 32'(write_reg), 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ll_ready), 32'd1);
        chk("post_rst_regwrite", 32'(regWrite), 32'd0);

        // Single WB write
        wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'd55;
        tick();
        wb_valid = 1'b0;
        chk("wb_regwrite", 32'(regWrite), 32'd1);
        chk("wb_wreg", 32'(write_reg), 32'd1);
        chk("wb_wdata", write_data, 32'd55);
        tick();
        chk("wb_regwrite_off", 32'(regWrite), 32'd0);

        // LL buffered behind WB priority
        wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h22;
        ll_valid = 1'b1; ll_reg = 5'd3; ll_data = 32'hAAAA;
        chk_reg_1 = 5'd3;
        tick();
        ll_valid = 1'b0;
        chk("ll_count1", 32'(ll_count), 32'd1);
        chk("ll_wb_wreg", 32'(write_reg), 32'd2);
        chk("ll_hit_fifo", 32'(chk_hit_1), 32'd1);
        tick();
        tick();
        chk("ll_still_buf", 32'(ll_count), 32'd1);
        wb_valid = 1'b0;
        tick();
        chk("ll_pop_wreg", 32'(write_reg), 32'd3);
        chk("ll_pop_wdata", write_data, 32'hAAAA);
        chk("ll_pop_regwrite", 32'(regWrite), 32'd1);
        chk("ll_pop_count", 32'(ll_count), 32'd0);
        chk("ll_hit_out", 32'(chk_hit_1), 32'd1);
        tick();
        chk("ll_idle_regwrite", 32'(regWrite), 32'd0);
        chk("ll_hit_clear", 32'(chk_hit_1), 32'd0);

        // Fill the FIFO while WB is continuously busy
        wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            ll_valid = 1'b1; ll_reg = 5'(4 + i); ll_data = 32'(100 + i);
            tick();
        end
        chk("full_count", 32'(ll_count), 32'd4);
        chk("full_ready", 32'(ll_ready), 32'd0);
        ll_reg = 5'd8; ll_data = 32'd200;
        chk_reg_2 = 5'd6;
        #1;
        chk("full_hit_6", 32'(chk_hit_2), 32'd1);
        tick();
        chk("full_no_push", 32'(ll_count), 32'd4);
        chk_reg_2 = 5'd8;
        #1;
        chk("full_hit_8", 32'(chk_hit_2), 32'd0);
        ll_valid = 1'b0; wb_valid = 1'b0;
        tick();
        chk("drain_wreg4", 32'(write_reg), 32'd4);
        chk("drain_wdata4", write_data, 32'd100);
        chk("drain_count3", 32'(ll_count), 32'd3);
        chk("drain_ready", 32'(ll_ready), 32'd1);
        tick();
        chk("drain_wreg5", 32'(write_reg), 32'd5);
        tick();
        chk("drain_wreg6", 32'(write_reg), 32'd6);
        tick();
        chk("drain_wreg7", 32'(write_reg), 32'd7);
        chk("drain_wdata7", write_data, 32'd103);
        tick();
        chk("drain_done_rw", 32'(regWrite), 32'd0);
        chk("drain_done_cnt", 32'(ll_count), 32'd0);

        // Starvation guard with WB held high
        wb_valid = 1'b1; wb_reg = 5'd10; wb_data = 32'hBEEF;
        ll_valid = 1'b1; ll_reg = 5'd9; ll_data = 32'h1234;
        tick();
        ll_valid = 1'b0;
        repeat (7) tick();
        chk("starve_no_stall", 32'(wb_stall), 32'd0);
        tick();
        chk("starve_stall", 32'(wb_stall), 32'd1);
        chk("starve_count", 32'(ll_count), 32'd1);
        chk("starve_wb_wreg", 32'(write_reg), 32'd10);
        tick();
        chk("starve_stall_off", 32'(wb_stall), 32'd0);
        chk("starve_ll_wreg", 32'(write_reg), 32'd9);
        chk("starve_ll_wdata", write_data, 32'h1234);
        chk("starve_ll_count", 32'(ll_count), 32'd0);
        tick();
        wb_valid = 1'b0;
        chk("starve_held_wreg", 32'(write_reg), 32'd10);
        chk("starve_held_wdata", write_data, 32'hBEEF);
        chk("starve_held_rw", 32'(regWrite), 32'd1);

        // Register 0 handling
        wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'd77;
        tick();
        wb_valid = 1'b0;
        chk("r0_wb_regwrite", 32'(regWrite), 32'd0);
        ll_valid = 1'b1; ll_reg = 5'd0; ll_data = 32'd88;
        #1;
        chk("r0_ll_ready", 32'(ll_ready), 32'd1);
        tick();
        ll_valid = 1'b0;
        chk("r0_ll_count", 32'(ll_count), 32'd0);
        chk_reg_1 = 5'd0;
        #1;
        chk("r0_hit", 32'(chk_hit_1), 32'd0);
        tick();
        chk("r0_no_pop", 32'(regWrite), 32'd0);

        // Asynchronous reset discards buffered entries
        ll_valid = 1'b1; ll_reg = 5'd12; ll_data = 32'd12;
        tick();
        ll_reg = 5'd13; ll_data = 32'd13;
        tick();
        ll_valid = 1'b0;
        chk("arst_pre_count", 32'(ll_count), 32'd1);
        chk("arst_pre_wreg", 32'(write_reg), 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(ll_count), 32'd0);
        chk("arst_regwrite", 32'(regWrite), 32'd0);
        chk("arst_wreg", 32'(write_reg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_after_rw", 32'(regWrite), 32'd0);
        chk("arst_after_cnt", 32'(ll_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (write_reg / write_data / regWrite) between two requesters. The first is the in-order writeback stage (WB), which has priority. The second is the long-latency unit (LL, mul/div), whose results wait in a small FIFO until a free write slot appears. A starvation guard forces a WB stall so the LL FIFO drains. Pending-destination lookups let decode stall on registers whose writes are still buffered.

Parameters:
DEPTH, 4, LL holding FIFO entries (power of 2, >=2)
MAX_WAIT, 8, cycles the FIFO head may wait before a forced drain slot (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wb_valid  input  1  WB has a write this cycle
wb_reg  input  5  WB destination register
wb_data  input  32  WB write data
wb_stall  output  1  registered; WB must hold its request this cycle
ll_valid  input  1  LL result offered
ll_reg  input  5  LL destination register
ll_data  input  32  LL result data
ll_ready  output  1  FIFO can accept (= !full)
chk_reg_1  input  5  decode source register 1 lookup
chk_reg_2  input  5  decode source register 2 lookup
chk_hit_1  output  1  chk_reg_1 has a pending write
chk_hit_2  output  1  chk_reg_2 has a pending write
write_reg  output  5  to register file
write_data  output  32  to register file
regWrite  output  1  to register file, write enable
ll_count  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, ll_count=0, wait counter=0, state=NORMAL, wb_stall=0, regWrite=0, write_reg=0, write_data=0. ll_ready=1 once reset is released. A reset mid-drain discards all buffered entries.
- WB accept: wb_valid && !wb_stall. LL push: ll_valid && ll_ready.
- Write outputs are registered, so an accepted write appears on write_reg/write_data/regWrite in the next cycle, held for exactly one cycle.
- Slot selection each cycle:
  - NORMAL: a WB accept wins the slot. Otherwise, if the FIFO is non-empty, pop the head into the slot. Otherwise regWrite=0 next cycle.
  - DRAIN: wb_stall=1 and the FIFO head is written. WB is not accepted.
- Register 0: a WB write to reg 0 is accepted (no stall side effects) but drives regWrite=0. An LL push to reg 0 completes the handshake but is not enqueued.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - No bypass: an entry pushed into an empty FIFO is poppable the following cycle at the earliest.
  - Simultaneous push and pop keep ll_count unchanged.
  - Push while full cannot happen because ll_ready=0.
- Wait counter:
  - Clears when the FIFO is empty or the head is popped.
  - Otherwise increments while the FIFO is non-empty and the head is not popped.
  - When it reaches MAX_WAIT in NORMAL, the next state is DRAIN.
- FSM:
  - NORMAL -> DRAIN as above.
  - DRAIN lasts exactly one cycle (one pop), then returns to NORMAL with the counter cleared.
  - wb_stall is the registered DRAIN indication, so it is high exactly during DRAIN.
- Lookups (combinational): chk_hit_n=1 if chk_reg_n!=0 and it matches either of:
  - any valid FIFO entry's register, or
  - the output register while regWrite=1.
  chk_reg_n=0 always returns 0.
- Ordering: buffered LL entries for the same register pop in push order. The pipeline uses chk_hit_* to prevent WB/LL WAW conflicts; the arbiter does not reorder them.

Test Plan:
- Reset values: hold rst_n=0, then release -> regWrite=0, wb_stall=0, ll_ready=1, ll_count=0; asserting rst_n mid-cycle clears asynchronously.
- WB write: wb_valid=1, wb_reg=1, wb_data=55 for one cycle -> next cycle regWrite=1, write_reg=1, write_data=55; regWrite=0 the cycle after.
- LL buffering and priority: push LL reg 3 = 0xAAAA while WB writes reg 2 for 3 cycles -> ll_count=1, chk_reg_1=3 gives chk_hit_1=1; the first WB-idle cycle pops it so write_reg=3 one cycle later, then ll_count=0 and chk_hit_1=0.
- Full FIFO: push DEPTH=4 entries (regs 4..7) with WB continuously busy -> ll_ready=0 and ll_count=4; a 5th ll_valid is not accepted; after one pop, ll_ready=1 again.
- Starvation guard: one LL entry (reg 9 = 0x1234) with wb_valid held high -> after MAX_WAIT=8 waiting cycles wb_stall=1 for one cycle, the reg 9 write appears, and the held WB request is written in the following cycle.
- Register 0: WB to reg 0 -> regWrite stays 0; LL push to reg 0 -> ll_count unchanged; chk_reg_1=0 -> chk_hit_1=0.
